// File: rtl/xor_reduce_pipe_if.sv
// Beat-in / result-out handshake bundle for the XOR reduction array.
// master = producer/consumer side (bench or integrator), slave = the array.
interface xor_reduce_pipe_if #(
  parameter int LANES = 8,
  parameter int FANIN = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*FANIN-1:0] in_data;
  logic                   in_acc;
  logic                   acc_clr;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_data;

  modport master (
    output in_valid, in_data, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xor_reduce_pipe.sv
// Pipelined per-lane XOR reduction with valid/ready flow control, an optional
// mid-tree register and a running XOR accumulator for chained beats.
module xor_reduce_pipe #(
  parameter int LANES   = 8,
  parameter int FANIN   = 4,
  parameter int MID_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  xor_reduce_pipe_if.slave bus
);
  localparam int DEPTH   = $clog2(FANIN);
  localparam int MID_LVL = (DEPTH / 2 < 1) ? 1 : DEPTH / 2;
  localparam int MID_W   = FANIN >> MID_LVL;

  // In-place halving keeps the (b0^b1)^(b2^b3) pairing at every level.
  function automatic logic tree_bit(input logic [FANIN-1:0] v);
    logic [FANIN-1:0] r;
    r = v;
    for (int k = 0; k < DEPTH; k++)
      for (int j = 0; j < FANIN / 2; j++)
        r[j] = r[2*j] ^ r[2*j+1];
    return r[0];
  endfunction

  function automatic logic [MID_W-1:0] mid_reduce(input logic [FANIN-1:0] v);
    logic [FANIN-1:0] r;
    r = v;
    for (int k = 0; k < MID_LVL; k++)
      for (int j = 0; j < FANIN / 2; j++)
        r[j] = r[2*j] ^ r[2*j+1];
    return r[MID_W-1:0];
  endfunction

  function automatic logic tail_bit(input logic [MID_W-1:0] v);
    logic [MID_W-1:0] r;
    r = v;
    for (int k = 0; k < DEPTH - MID_LVL; k++)
      for (int j = 0; j < MID_W / 2; j++)
        r[j] = r[2*j] ^ r[2*j+1];
    return r[0];
  endfunction

  logic [LANES-1:0] w_tree;
  logic             w_src_valid;
  logic             w_src_acc;
  logic             w_out_drain;
  logic             w_out_open;
  logic             w_out_load;
  logic [LANES-1:0] w_out_next;

  logic             r_out_valid;
  logic [LANES-1:0] r_out_data;
  logic [LANES-1:0] r_acc;

  assign w_out_drain = r_out_valid && bus.out_ready;
  assign w_out_open  = !r_out_valid || w_out_drain;
  assign w_out_load  = w_src_valid && w_out_open;
  assign w_out_next  = w_src_acc ? (w_tree ^ r_acc) : w_tree;

  generate
    if (MID_REG == 0) begin : g_direct
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_tree[i] = tree_bit(bus.in_data[i*FANIN +: FANIN]);
      end
      assign w_src_valid  = bus.in_valid;
      assign w_src_acc    = bus.in_acc;
      assign bus.in_ready = w_out_open;
    end else begin : g_mid
      logic                   r_s1_valid;
      logic                   r_s1_acc;
      logic [LANES*MID_W-1:0] r_s1_data;
      logic [LANES*MID_W-1:0] w_mid;
      logic                   w_s1_fire;

      for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_mid[i*MID_W +: MID_W] = mid_reduce(bus.in_data[i*FANIN +: FANIN]);
        assign w_tree[i]               = tail_bit(r_s1_data[i*MID_W +: MID_W]);
      end

      assign w_src_valid  = r_s1_valid;
      assign w_src_acc    = r_s1_acc;
      // S1 frees up in the same cycle it hands its beat to S_out.
      assign bus.in_ready = !r_s1_valid || w_out_load;
      assign w_s1_fire    = bus.in_valid && bus.in_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_valid <= 1'b0;
          r_s1_acc   <= 1'b0;
          r_s1_data  <= '0;
        end else if (w_s1_fire) begin
          r_s1_valid <= 1'b1;
          r_s1_acc   <= bus.in_acc;
          r_s1_data  <= w_mid;
        end else if (w_out_load) begin
          r_s1_valid <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_acc       <= '0;
    end else begin
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_next;
      end else if (w_out_drain) begin
        r_out_valid <= 1'b0;
      end
      // A clear beats a same-cycle accumulate; that beat still saw the old value.
      if (bus.acc_clr)
        r_acc <= '0;
      else if (w_out_load && w_src_acc)
        r_acc <= w_out_next;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule
